// File: rtl/uart_tx.sv
// UART transmitter: frames parallel words (start, LSB-first data, optional
// parity, 1-2 stop bits) onto a single line, stepping on baud_clk rising edges.
module uart_tx #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_clk,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int unsigned      IDX_W     = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [IDX_W-1:0]     idx_q, idx_d, nxt_idx;
  logic                 par_q, par_d;
  logic                 pending_q, pending_d;
  logic                 tx_q, tx_d;
  logic                 stop_q, stop_d;
  logic                 baud_q;
  logic                 baud_tick;
  logic                 final_stop;
  logic                 accept;

  assign baud_tick  = baud_clk & ~baud_q;
  assign final_stop = (state_q == S_STOP) && (stop_q == LAST_STOP);
  assign nxt_idx    = idx_q + IDX_W'(1);
  assign accept     = tx_valid & tx_ready;
  assign tx         = tx_q;

  // State register plus datapath registers; reset forces an idle, high line.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      data_q    <= '0;
      idx_q     <= '0;
      par_q     <= 1'b0;
      pending_q <= 1'b0;
      tx_q      <= 1'b1;
      stop_q    <= 1'b0;
      baud_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      idx_q     <= idx_d;
      par_q     <= par_d;
      pending_q <= pending_d;
      tx_q      <= tx_d;
      stop_q    <= stop_d;
      baud_q    <= baud_clk;
    end
  end

  // Next-state logic: handshake loads the word, each baud tick advances the frame.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    idx_d     = idx_q;
    par_d     = par_q;
    pending_d = pending_q;
    tx_d      = tx_q;
    stop_d    = stop_q;

    // Acceptance only happens in IDLE or the final stop bit, so the data
    // register is never needed by the frame on the same edge.
    if (accept) begin
      data_d    = tx_data;
      par_d     = (PARITY == 1) ? ~(^tx_data) : (^tx_data);
      pending_d = 1'b1;
    end

    if (baud_tick) begin
      case (state_q)
        S_IDLE: begin
          if (pending_q) begin
            state_d   = S_START;
            tx_d      = 1'b0;
            pending_d = 1'b0;
          end
        end
        S_START: begin
          state_d = S_DATA;
          tx_d    = data_q[0];
          idx_d   = '0;
        end
        S_DATA: begin
          if (idx_q == LAST_IDX) begin
            if (PARITY != 0) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
              stop_d  = 1'b0;
            end
          end else begin
            idx_d = nxt_idx;
            tx_d  = data_q[nxt_idx];
          end
        end
        S_PARITY: begin
          state_d = S_STOP;
          tx_d    = 1'b1;
          stop_d  = 1'b0;
        end
        S_STOP: begin
          if (final_stop) begin
            if (pending_q) begin
              state_d   = S_START;
              tx_d      = 1'b0;
              pending_d = 1'b0;
            end else begin
              state_d = S_IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
        end
      endcase
    end
  end

  // Outputs: ready in IDLE or during the last stop bit when nothing is pending.
  always_comb begin
    tx_ready = ~reset & ~pending_q & ((state_q == S_IDLE) | final_stop);
    busy     = (state_q != S_IDLE) | pending_q;
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four configurations share clock, reset and baud.
module tb_uart_tx;

  logic       clk;
  logic       reset;
  logic       baud_clk;
  logic       baud_en;
  logic [2:0] bcnt;
  logic [3:0] vld, rdy, txl, bsy;
  logic [7:0] dat0, dat1, dat2;
  logic [6:0] dat3;
  logic [1:0] sel;
  int         n_cmp, n_bad;

  typedef struct {
    logic [1:0]  sel;
    logic [7:0]  data;
    int          nbits;
    logic [15:0] line;
    logic [15:0] rmask;
  } vec_t;

  vec_t tbl [8];

  uart_tx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .reset(reset), .baud_clk(baud_clk), .tx_data(dat0), .tx_valid(vld[0]),
    .tx_ready(rdy[0]), .tx(txl[0]), .busy(bsy[0]));
  uart_tx #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .reset(reset), .baud_clk(baud_clk), .tx_data(dat1), .tx_valid(vld[1]),
    .tx_ready(rdy[1]), .tx(txl[1]), .busy(bsy[1]));
  uart_tx #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .reset(reset), .baud_clk(baud_clk), .tx_data(dat2), .tx_valid(vld[2]),
    .tx_ready(rdy[2]), .tx(txl[2]), .busy(bsy[2]));
  uart_tx #(.DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
    .clk(clk), .reset(reset), .baud_clk(baud_clk), .tx_data(dat3), .tx_valid(vld[3]),
    .tx_ready(rdy[3]), .tx(txl[3]), .busy(bsy[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Baud source: 8 clk cycles per period, changes on the falling clk edge.
  initial begin
    baud_clk = 1'b0;
    bcnt     = '0;
    forever begin
      @(negedge clk);
      if (baud_en) begin
        bcnt     = bcnt + 3'd1;
        baud_clk = bcnt[2];
      end
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic set_data(input logic [1:0] s, input logic [7:0] d);
    case (s)
      2'd0: dat0 = d;
      2'd1: dat1 = d;
      2'd2: dat2 = d;
      default: dat3 = d[6:0];
    endcase
  endtask

  // Offer a word; returns on the sample point just after the accepting edge.
  task automatic send(input logic [1:0] s, input logic [7:0] d, input bit keep);
    bit ok;
    ok  = 1'b0;
    sel = s;
    set_data(s, d);
    vld[s] = 1'b1;
    for (int w = 0; w < 200 && !ok; w++) begin
      if (rdy[s]) ok = 1'b1;
      @(negedge clk);
    end
    if (!keep) vld[s] = 1'b0;
    check($sformatf("handshake_u%0d", s), int'(ok), 1);
  endtask

  // Wait for a start bit (current sample included), then sample n bit periods.
  // A handshake seen during the frame drops tx_valid right after its edge.
  task automatic capture(input int n, output logic [15:0] line, output logic [15:0] rmask,
                         output int glitches, output int lat, output int hs, output int rcnt);
    bit         drop;
    logic [3:0] bi;
    drop = 1'b0; lat = -1; line = '0; rmask = '0; glitches = 0; hs = 0; rcnt = 0;
    for (int w = 0; w <= 40; w++) begin
      if (w > 0) @(negedge clk);
      if (txl[sel] == 1'b0) begin
        lat = w;
        break;
      end
    end
    if (lat >= 0) begin
      for (int c = 0; c < n * 8; c++) begin
        if (c > 0) begin
          @(negedge clk);
          if (drop) begin
            vld[sel] = 1'b0;
            drop     = 1'b0;
          end
        end
        bi = 4'(c / 8);
        if (c % 8 == 0) line[bi] = txl[sel];
        else if (txl[sel] != line[bi]) glitches++;
        if (rdy[sel]) begin
          rmask[bi] = 1'b1;
          rcnt++;
        end
        if (vld[sel] && rdy[sel]) begin
          hs++;
          drop = 1'b1;
        end
      end
    end
  endtask

  initial begin
    logic [15:0] line, rmask;
    int          gl, lat, hs, rc, txlow;

    n_cmp = 0; n_bad = 0;
    reset = 1'b1; baud_en = 1'b1; vld = '0; sel = '0;
    dat0 = '0; dat1 = '0; dat2 = '0; dat3 = '0;

    //            sel   data   n   line      ready mask
    tbl[0] = '{2'd0, 8'h55, 10, 16'h02AA, 16'h0200};
    tbl[1] = '{2'd0, 8'hA5, 10, 16'h034A, 16'h0200};
    tbl[2] = '{2'd2, 8'hA5, 11, 16'h054A, 16'h0400};
    tbl[3] = '{2'd1, 8'hA5, 11, 16'h074A, 16'h0400};
    tbl[4] = '{2'd2, 8'h01, 11, 16'h0602, 16'h0400};
    tbl[5] = '{2'd1, 8'h01, 11, 16'h0402, 16'h0400};
    tbl[6] = '{2'd3, 8'h7F, 10, 16'h03FE, 16'h0200};
    tbl[7] = '{2'd0, 8'h00, 10, 16'h0200, 16'h0200};

    // Reset state
    repeat (5) @(negedge clk);
    check("reset_tx", int'(txl), 32'hF);
    check("reset_busy", int'(bsy), 0);
    check("reset_ready", int'(rdy), 0);
    reset = 1'b0;
    #1;
    check("ready_after_reset", int'(rdy), 32'hF);
    @(negedge clk);

    // Table: one frame per record
    for (int i = 0; i < 8; i++) begin
      send(tbl[i].sel, tbl[i].data, 1'b0);
      capture(tbl[i].nbits, line, rmask, gl, lat, hs, rc);
      check($sformatf("v%0d_latency_ok", i), int'(lat >= 1 && lat <= 8), 1);
      check($sformatf("v%0d_line", i), int'(line), int'(tbl[i].line));
      check($sformatf("v%0d_glitches", i), gl, 0);
      check($sformatf("v%0d_ready_mask", i), int'(rmask), int'(tbl[i].rmask));
      check($sformatf("v%0d_ready_cycles", i), rc, 8);
      check($sformatf("v%0d_busy_last", i), int'(bsy[sel]), 1);
      @(negedge clk);
      check($sformatf("v%0d_busy_end", i), int'(bsy[sel]), 0);
      check($sformatf("v%0d_ready_end", i), int'(rdy[sel]), 1);
    end

    // Back-to-back: 0x00 then 0xFF with tx_valid held
    send(2'd0, 8'h00, 1'b1);
    dat0 = 8'hFF;
    capture(10, line, rmask, gl, lat, hs, rc);
    check("b2b_f1_line", int'(line), 32'h200);
    check("b2b_f1_glitches", gl, 0);
    check("b2b_f1_handshakes", hs, 1);
    check("b2b_f1_ready_cycles", rc, 1);
    check("b2b_f1_ready_mask", int'(rmask), 32'h200);
    @(negedge clk);
    check("b2b_no_gap_tx", int'(txl[0]), 0);
    check("b2b_no_gap_busy", int'(bsy[0]), 1);
    capture(10, line, rmask, gl, lat, hs, rc);
    check("b2b_f2_latency", lat, 0);
    check("b2b_f2_line", int'(line), 32'h3FE);
    check("b2b_f2_glitches", gl, 0);
    @(negedge clk);
    check("b2b_busy_end", int'(bsy[0]), 0);

    // Reset during data bit 3 of 0x00
    send(2'd0, 8'h00, 1'b0);
    lat = -1;
    for (int w = 0; w <= 40; w++) begin
      if (w > 0) @(negedge clk);
      if (txl[0] == 1'b0) begin
        lat = w;
        break;
      end
    end
    check("mid_reset_start_seen", int'(lat >= 0), 1);
    repeat (34) @(negedge clk);
    check("mid_reset_pre_tx", int'(txl[0]), 0);
    check("mid_reset_pre_busy", int'(bsy[0]), 1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_reset_tx", int'(txl[0]), 1);
    check("mid_reset_busy", int'(bsy[0]), 0);
    check("mid_reset_ready_low", int'(rdy[0]), 0);
    reset = 1'b0;
    #1;
    check("mid_reset_ready_release", int'(rdy[0]), 1);
    send(2'd0, 8'h55, 1'b0);
    capture(10, line, rmask, gl, lat, hs, rc);
    check("post_reset_line", int'(line), 32'h2AA);
    check("post_reset_glitches", gl, 0);
    @(negedge clk);

    // Stalled baud: tx_valid held 100 cycles with no ticks
    baud_en = 1'b0;
    sel = 2'd0;
    dat0 = 8'h3C;
    vld[0] = 1'b1;
    hs = 0; txlow = 0;
    for (int c = 0; c < 100; c++) begin
      if (vld[0] && rdy[0]) hs++;
      if (txl[0] == 1'b0) txlow++;
      @(negedge clk);
    end
    vld[0] = 1'b0;
    check("stall_handshakes", hs, 1);
    check("stall_tx_low_cycles", txlow, 0);
    check("stall_busy", int'(bsy[0]), 1);
    baud_en = 1'b1;
    capture(10, line, rmask, gl, lat, hs, rc);
    check("stall_start_seen", int'(lat >= 0), 1);
    check("stall_line", int'(line), 32'h278);
    check("stall_glitches", gl, 0);
    @(negedge clk);
    check("stall_busy_end", int'(bsy[0]), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter that consumes the divided baud clock produced by the clock divider and shifts parallel words out on a single line as UART frames. Each frame is a start bit, data bits LSB first, an optional parity bit, and one or two stop bits. The block sits between a producer using a valid/ready handshake and the board's TX pin. Everything runs in the single `clk` domain. `baud_clk` is treated as a registered level in that domain, not as a clock.

## Interface

Parameters:
- `DATA_BITS`, default 8: data bits per frame; legal range 5–9.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: legal values 1 or 2.

Ports:
- `clk`, in, 1: system clock; every register is clocked on its rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `baud_clk`, in, 1: divider output, synchronous to `clk`; one bit period equals one `baud_clk` period.
- `tx_data`, in, `DATA_BITS`: word to send; sampled on handshake.
- `tx_valid`, in, 1: producer has a word.
- `tx_ready`, out, 1: block accepts a word this cycle.
- `tx`, out, 1: serial line; idles high.
- `busy`, out, 1: a frame is in progress or a word is pending.

## Operation

- **Tick generation:** `baud_q` registers `baud_clk`. `baud_tick = baud_clk & ~baud_q`, which gives exactly one `clk` cycle per `baud_clk` rising edge. `baud_q` resets to 1 so no spurious tick follows reset.
- **Handshake:** a word transfers on a `clk` edge where `tx_valid & tx_ready`. On transfer:
  - `tx_data` is latched into the shift register;
  - the parity bit is computed from the latched word;
  - `pending` is set.
- **`tx_ready`:** combinational and forced 0 while `reset` is high. It is 1 when `~pending` and either:
  - state is IDLE, or
  - state is STOP on its final stop bit.
- **State machine** (`tx` is registered and reflects the state):
  - **IDLE** (`tx`=1): on a tick with `pending`, go to START, drive `tx`=0, clear `pending`.
  - **START**: on a tick, go to DATA, drive bit 0, set bit index to 0.
  - **DATA**: on each tick, advance the index and drive the next bit. On the tick after bit `DATA_BITS-1`, go to PARITY if `PARITY`≠0, otherwise to STOP (`tx`=1).
  - **PARITY**: holds the bit. Odd parity makes the total ones count in data plus parity odd; even makes it even. On a tick, go to STOP, drive `tx`=1, set stop count to 0.
  - **STOP**: on a tick that ends a non-final stop bit, increment the stop count. On the tick ending the final stop bit:
    - if `pending` is set, go straight to START (`tx`=0, clear `pending`), so there is no idle gap;
    - otherwise go to IDLE.
- **Stop-bit latch:** a word accepted during the final stop bit is held in the now-free shift register.
- **`busy`:** equals `(state != IDLE) | pending`.
- **`tx_valid` without ticks:** if `tx_valid` is held while no ticks arrive, at most one word is accepted and no line activity occurs.
- **Reset:**
  - `reset` high on an edge sets state IDLE, clears `pending`, `tx`=1, `busy`=0, and `baud_q`=1.
  - This applies mid-frame as well: the frame is abandoned and the line returns high on the next cycle.
  - Handshakes are ignored while `reset` is high.
  - `tx_ready`=1 on the first cycle with `reset` low.

## Timing

- `tx` changes on the `clk` edge where `baud_tick` is high, one cycle after `baud_clk` rises.
- Each line bit lasts exactly one `baud_clk` period (P `clk` cycles).
- Latency from handshake to the start-bit edge: from the next `baud_tick` edge at the earliest (1 cycle) to P cycles at the latest.
- Frame length is `1 + DATA_BITS + (PARITY≠0) + STOP_BITS` bit periods.
- Back-to-back words accepted during the final stop bit produce contiguous frames with exactly `STOP_BITS` stop periods between them.
- `baud_tick` and a handshake in the same cycle:
  - the handshake is accepted;
  - the tick is applied to the state as it stood before that edge;
  - a word accepted in IDLE on a tick edge starts on the following tick.

## Test plan

- **0x55, 8N1, P=8:** accept 0x55 → `tx` sequence 0,1,0,1,0,1,0,1,0,1. Each level is held exactly 8 cycles. `busy` drops to 0 when the stop bit ends, and `tx_ready`=1 again.
- **Parity:** send 0xA5 with `PARITY`=2 → parity bit 0. With `PARITY`=1 → parity bit 1. Frame is 11 bit periods.
- **Back-to-back:** hold `tx_valid` with words 0x00 then 0xFF → the second start bit follows the first frame's stop bit after exactly one period (8 cycles high). `tx_ready` pulses once during that stop bit.
- **Reset mid-frame:** assert `reset` during data bit 3 of 0x00 → `tx`=1 and `busy`=0 the next cycle. Releasing reset gives `tx_ready`=1, and a new word (e.g. 0x55) transmits correctly.
- **Stalled baud:** `baud_clk` held constant, `tx_valid`=1 with 0x3C for 100 cycles → exactly one handshake, `tx` stays 1, `busy`=1. Restarting `baud_clk` sends 0x3C.
- **`STOP_BITS`=2, `DATA_BITS`=7:** accept 0x7F → 0, seven 1s, then two stop periods high. `tx_ready` asserts only during the second stop period.
